// File: rtl/svo_tmds_dec_pkg.sv
// rtl/svo_tmds_dec_pkg.sv - shared TMDS control-token constants
//
// Purpose: the four TMDS control-period code words. The transmit encoder
// imports the same package, so both ends of the link use one definition.
// Ports: none (package).

package svo_tmds_dec_pkg;

  // Control tokens as din[9:0], din[0] first on the wire.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/svo_tmds_dec_word.sv
// rtl/svo_tmds_dec_word.sv - combinational TMDS word classifier and data decoder
//
// Purpose: classify one 10-bit TMDS word as a control token or data, and
// produce the token's control value and the word's decoded data byte.
// Ports:
//   din      in  10  TMDS word, din[0] first on the wire
//   is_token out 1   din is one of the four control tokens
//   ctrl     out 2   control value of the token (00 when not a token)
//   q        out 8   data byte decoded from din (meaningful for data words)

module svo_tmds_dec_word
  import svo_tmds_dec_pkg::*;
(
  input  logic [9:0] din,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] q
);

  logic [7:0] d;
  logic [6:0] x;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (din)
      TMDS_CTRL_00: ctrl = 2'b00;
      TMDS_CTRL_01: ctrl = 2'b01;
      TMDS_CTRL_10: ctrl = 2'b10;
      TMDS_CTRL_11: ctrl = 2'b11;
      default:      is_token = 1'b0;
    endcase
  end

  // din[9] flags a DC-balance inversion; din[8] picks XOR vs XNOR chaining.
  always_comb begin
    d = din[9] ? ~din[7:0] : din[7:0];
    x = d[7:1] ^ d[6:0];
    q = {(din[8] ? x : ~x), d[0]};
  end

endmodule

// File: rtl/svo_tmds_dec.sv
// rtl/svo_tmds_dec.sv - TMDS channel decoder with bitslip-based word alignment
//
// Purpose: searches for word alignment by pulsing the deserializer bitslip
// until one control token repeats CTRL_RUN times, then decodes each word into
// de / ctrl / dout. Lock is dropped after LOSS_CYCLES words without a token.
// Optional feature macro: SVO_TMDS_DEC_STATS_EN adds lock_loss_cnt.
// Ports:
//   clk           in  1   pixel clock
//   resetn        in  1   asynchronous active-low reset
//   din           in  10  deserialized word, din[0] first on the wire
//   de            out 1   dout holds pixel data
//   ctrl          out 2   decoded control token (when de=0 and aligned=1)
//   dout          out 8   decoded data byte
//   aligned       out 1   word alignment achieved
//   bitslip       out 1   one-cycle pulse to the deserializer CALIB input
//   lock_loss_cnt out 8   saturating count of lock losses (STATS_EN only)

module svo_tmds_dec
  import svo_tmds_dec_pkg::*;
#(
  parameter int CTRL_RUN      = 16,
  parameter int SEARCH_CYCLES = 2048,
  parameter int SLIP_WAIT     = 16,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout,
  output logic       aligned,
  output logic       bitslip
`ifdef SVO_TMDS_DEC_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  // run_cnt must hold CTRL_RUN itself; the shared timer only counts to N-1.
  localparam int RUN_W    = $clog2(CTRL_RUN + 1);
  localparam int TMR_SPAN = (LOSS_CYCLES >= SEARCH_CYCLES)
                          ? ((LOSS_CYCLES >= SLIP_WAIT) ? LOSS_CYCLES : SLIP_WAIT)
                          : ((SEARCH_CYCLES >= SLIP_WAIT) ? SEARCH_CYCLES : SLIP_WAIT);
  localparam int TMR_W    = $clog2(TMR_SPAN);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    WAIT,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [9:0]       prev_word;

  logic             w_tok;
  logic [1:0]       w_ctrl;
  logic [7:0]       w_q;
  logic             decode_en;

  svo_tmds_dec_word u_word (
    .din      (din),
    .is_token (w_tok),
    .ctrl     (w_ctrl),
    .q        (w_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      tmr       <= '0;
      prev_word <= '0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_nxt;
      tmr       <= tmr_nxt;
      prev_word <= din;
    end
  end

  // One timer serves all states: search dwell, post-slip settle, loss watch.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    tmr_nxt   = tmr;
    case (state)
      SEARCH: begin
        if (!w_tok)
          run_nxt = '0;
        else if (din != prev_word)
          run_nxt = RUN_W'(1);
        else if (run_cnt != RUN_W'(CTRL_RUN))
          run_nxt = run_cnt + RUN_W'(1);

        // Lock wins over the dwell timer expiring in the same cycle.
        if (run_nxt == RUN_W'(CTRL_RUN)) begin
          state_nxt = LOCKED;
          run_nxt   = '0;
          tmr_nxt   = '0;
        end else if (tmr == TMR_W'(SEARCH_CYCLES - 1)) begin
          state_nxt = SLIP;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      SLIP: begin
        state_nxt = WAIT;
        run_nxt   = '0;
        tmr_nxt   = '0;
      end
      WAIT: begin
        run_nxt = '0;
        if (tmr == TMR_W'(SLIP_WAIT - 1)) begin
          state_nxt = SEARCH;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      LOCKED: begin
        run_nxt = '0;
        if (w_tok) begin
          tmr_nxt = '0;
        end else if (tmr == TMR_W'(LOSS_CYCLES - 1)) begin
          state_nxt = SEARCH;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      default: begin
        state_nxt = SEARCH;
        run_nxt   = '0;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Outputs follow the next state so the locking token is itself decoded and
  // the word that expires the loss timer is already forced to idle.
  assign decode_en = (state_nxt == LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de      <= 1'b0;
      ctrl    <= 2'b00;
      dout    <= 8'h00;
      aligned <= 1'b0;
      bitslip <= 1'b0;
    end else begin
      aligned <= decode_en;
      bitslip <= (state_nxt == SLIP);
      de      <= decode_en && !w_tok;
      ctrl    <= (decode_en && w_tok) ? w_ctrl : 2'b00;
      dout    <= (decode_en && !w_tok) ? w_q : 8'h00;
    end
  end

`ifdef SVO_TMDS_DEC_STATS_EN
  logic lock_loss;

  assign lock_loss = (state == LOCKED) && (state_nxt == SEARCH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      lock_loss_cnt <= 8'h00;
    else if (lock_loss && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_svo_tmds_dec.sv
// tb/tb_svo_tmds_dec.sv - directed self-checking bench for svo_tmds_dec

module tb_svo_tmds_dec;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  // Encoder outputs: 0xA5 in both disparity variants, 0x00, 0xFF (two forms).
  localparam logic [9:0] W_A5_P = 10'b01_0110_0011;
  localparam logic [9:0] W_A5_N = 10'b11_1001_1100;
  localparam logic [9:0] W_00   = 10'b01_0000_0000;
  localparam logic [9:0] W_FF_P = 10'b00_1111_1111;
  localparam logic [9:0] W_FF_N = 10'b10_0000_0000;

  logic       clk;
  logic       resetn;
  logic [9:0] din;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] dout;
  logic       aligned;
  logic       bitslip;
`ifdef SVO_TMDS_DEC_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  svo_tmds_dec dut (
    .clk     (clk),
    .resetn  (resetn),
    .din     (din),
    .de      (de),
    .ctrl    (ctrl),
    .dout    (dout),
    .aligned (aligned),
    .bitslip (bitslip)
`ifdef SVO_TMDS_DEC_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] rotr(input logic [9:0] w, input int k);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < k; i++) r = {r[0], r[9:1]};
    return r;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    din    = 10'h000;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    din    = 10'h000;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({de, ctrl, dout, aligned, bitslip} !== 13'h0)
      $display("FAIL reset_outputs got %h expected %h", {de, ctrl, dout, aligned, bitslip}, 13'h0);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_lock();
    logic slip_seen;
    slip_seen = 1'b0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      din = T00;
      @(negedge clk);
      if (bitslip) slip_seen = 1'b1;
      if (i == 15) begin
        n_checks++;
        if (aligned !== 1'b0) $display("FAIL lock_early got %b expected %b", aligned, 1'b0);
        else n_pass++;
      end
      if (i == 16) begin
        n_checks++;
        if ({aligned, de, ctrl, dout} !== {1'b1, 1'b0, 2'b00, 8'h00})
          $display("FAIL lock_16th got %h expected %h", {aligned, de, ctrl, dout}, {1'b1, 1'b0, 2'b00, 8'h00});
        else n_pass++;
      end
    end
    n_checks++;
    if (slip_seen !== 1'b0) $display("FAIL lock_no_slip got %b expected %b", slip_seen, 1'b0);
    else n_pass++;
  endtask

  task automatic test_ctrl_decode();
    logic [9:0] toks [4];
    logic [1:0] exp  [4];
    toks = '{T01, T10, T11, T00};
    exp  = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      din = toks[i];
      @(negedge clk);
      n_checks++;
      if ({aligned, de, ctrl, dout} !== {1'b1, 1'b0, exp[i], 8'h00})
        $display("FAIL ctrl_tok%0d got %h expected %h", i, {aligned, de, ctrl, dout}, {1'b1, 1'b0, exp[i], 8'h00});
      else n_pass++;
    end
  endtask

  task automatic test_data_decode();
    logic [9:0] words [5];
    logic [7:0] exp   [5];
    words = '{W_A5_P, W_A5_N, W_00, W_FF_P, W_FF_N};
    exp   = '{8'hA5, 8'hA5, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      din = words[i];
      @(negedge clk);
      n_checks++;
      if ({de, ctrl, dout} !== {1'b1, 2'b00, exp[i]})
        $display("FAIL data_word%0d got %h expected %h", i, {de, ctrl, dout}, {1'b1, 2'b00, exp[i]});
      else n_pass++;
    end
  endtask

  task automatic test_loss();
    din = T00;
    @(negedge clk);
    for (int i = 1; i <= 4096; i++) begin
      din = W_A5_P;
      @(negedge clk);
      if (i == 4095) begin
        n_checks++;
        if ({aligned, de, dout} !== {1'b1, 1'b1, 8'hA5})
          $display("FAIL loss_hold got %h expected %h", {aligned, de, dout}, {1'b1, 1'b1, 8'hA5});
        else n_pass++;
      end
      if (i == 4096) begin
        n_checks++;
        if ({aligned, de, ctrl, dout} !== 12'h0)
          $display("FAIL loss_drop got %h expected %h", {aligned, de, ctrl, dout}, 12'h0);
        else n_pass++;
      end
    end
`ifdef SVO_TMDS_DEC_STATS_EN
    n_checks++;
    if (lock_loss_cnt !== 8'd1) $display("FAIL loss_count got %0d expected %0d", lock_loss_cnt, 1);
    else n_pass++;
`endif
  endtask

  task automatic test_slip_align();
    int rot, slips, cyc, last, first, gap_bad;
    logic locked;
    rot = 3; slips = 0; cyc = 0; last = 0; first = 0; gap_bad = 0; locked = 1'b0;
    do_reset();
    while (cyc < 10000 && !locked) begin
      din = rotr(T00, rot);
      @(negedge clk);
      cyc++;
      if (bitslip) begin
        slips++;
        if (slips == 1) first = cyc;
        else if (cyc - last != 2065) gap_bad++;
        last = cyc;
        if (rot > 0) rot--;
      end
      if (aligned) locked = 1'b1;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL slip_lock got %b expected %b", locked, 1'b1);
    else n_pass++;
    n_checks++;
    if (slips != 3) $display("FAIL slip_count got %0d expected %0d", slips, 3);
    else n_pass++;
    n_checks++;
    if (gap_bad != 0) $display("FAIL slip_spacing got %0d bad gaps expected %0d", gap_bad, 0);
    else n_pass++;
    n_checks++;
    if (first < 2048 || first > 2049) $display("FAIL slip_first got %0d expected %0d", first, 2048);
    else n_pass++;
  endtask

  task automatic test_reset_in_slip();
    int cyc;
    logic hit;
    cyc = 0; hit = 1'b0;
    do_reset();
    while (cyc < 3000 && !hit) begin
      din = W_A5_P;
      @(negedge clk);
      cyc++;
      if (bitslip) hit = 1'b1;
    end
    n_checks++;
    if (hit !== 1'b1) $display("FAIL rst_slip_reach got %b expected %b", hit, 1'b1);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({bitslip, aligned} !== 2'b00) $display("FAIL rst_slip_drop got %b expected %b", {bitslip, aligned}, 2'b00);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0; hit = 1'b0;
    while (cyc < 3000 && !hit) begin
      din = W_A5_P;
      @(negedge clk);
      cyc++;
      if (bitslip) hit = 1'b1;
    end
    n_checks++;
    if (!hit || cyc < 2048 || cyc > 2049)
      $display("FAIL rst_slip_restart got %0d expected %0d", cyc, 2048);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int slips;
    logic ever;
    slips = 0; ever = 1'b0;
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      din = i[0] ? T11 : T00;
      @(negedge clk);
      if (bitslip) slips++;
      if (aligned) ever = 1'b1;
    end
    n_checks++;
    if (ever !== 1'b0) $display("FAIL alt_never_align got %b expected %b", ever, 1'b0);
    else n_pass++;
    n_checks++;
    if (slips != 2) $display("FAIL alt_slips got %0d expected %0d", slips, 2);
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0;
    din    = 10'h000;
    test_reset();
    test_lock();
    test_ctrl_decode();
    test_data_decode();
    test_loss();
    test_slip_align();
    test_reset_in_slip();
    test_alternate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
